conv3x3_stream: RTL and testbench

- Streaming 3x3 convolution engine for the edge-detection pipeline.
- Two internal line buffers plus a 3x3 window register file.
- Runtime-selectable Gaussian, Sobel-X, Sobel-Y or Sobel-magnitude filtering, with parametrised image size and pixel width.
- Sits between pixel ingest and thresholding. Accepts one raster pixel per valid cycle and emits interior-pixel results with frame markers.

---
 rtl/conv_pkg.sv | 43 ++++
 rtl/line_buffer.sv | 26 ++
 rtl/conv3x3_stream.sv | 235 +++++++++++++++++++++++
 tb/tb_conv3x3_stream.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and kernel constants for the 3x3 streaming convolution engine.
package conv_pkg;

    // Filter selection, latched at frame start.
    typedef enum logic [1:0] {
        MODE_GAUSS     = 2'd0,
        MODE_SOBEL_X   = 2'd1,
        MODE_SOBEL_Y   = 2'd2,
        MODE_SOBEL_MAG = 2'd3
    } mode_e;

    // Frame sequencing states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    typedef logic signed [7:0] coef_t;

    // Row 0 of each kernel applies to the oldest line (r-2), column 0 to the oldest pixel (c-2).
    localparam coef_t KERNEL_GAUSS [3][3] = '{
        '{8'sd1, 8'sd2, 8'sd1},
        '{8'sd2, 8'sd4, 8'sd2},
        '{8'sd1, 8'sd2, 8'sd1}
    };

    localparam coef_t KERNEL_SOBEL_X [3][3] = '{
        '{-8'sd1, 8'sd0, 8'sd1},
        '{-8'sd2, 8'sd0, 8'sd2},
        '{-8'sd1, 8'sd0, 8'sd1}
    };

    localparam coef_t KERNEL_SOBEL_Y [3][3] = '{
        '{-8'sd1, -8'sd2, -8'sd1},
        '{ 8'sd0,  8'sd0,  8'sd0},
        '{ 8'sd1,  8'sd2,  8'sd1}
    };

    // Gaussian kernel weights sum to 16.
    localparam int unsigned GAUSS_SHIFT = 4;

endpackage

// File: rtl/line_buffer.sv
// One image row of storage; reads the old value at the address before overwriting it.
module line_buffer #(
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Combinational read returns the pixel from one row earlier at this column.
    assign rdata_o = mem_q[addr_i];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: two cascaded line buffers, a 3x3 window and a three-stage
// pipeline (window shift, multiply-accumulate, normalise/saturate). Border pixels produce
// no output; each result is tagged with frame start/end markers.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH  = 512,
    parameter int unsigned IMAGE_HEIGHT = 512,
    parameter int unsigned PIX_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode_i,
    input  logic             sof_i,
    input  logic             in_valid_i,
    input  logic [PIX_W-1:0] in_pixel_i,
    output logic             out_valid_o,
    output logic [PIX_W-1:0] out_pixel_o,
    output logic             out_sof_o,
    output logic             out_eof_o,
    output logic             busy_o
);

    localparam int unsigned CW = $clog2(IMAGE_WIDTH);
    localparam int unsigned RW = $clog2(IMAGE_HEIGHT);
    localparam int unsigned AW = PIX_W + 4;

    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    state_e          state_q, state_d;
    mode_e           mode_q, mode_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;

    logic            start;
    logic            accept;
    logic [CW-1:0]   pix_col;
    logic [RW-1:0]   pix_row;

    logic [PIX_W-1:0] lb1_rd, lb2_rd;
    logic [PIX_W-1:0] win_q [3][3];

    logic            v1_q, sof1_q, eof1_q;
    logic            v1_d, sof1_d, eof1_d;
    logic            v2_q, sof2_q, eof2_q;

    logic [AW-1:0]        pix_ext;
    logic [AW-1:0]        gsum_d, gsum_q;
    logic signed [AW-1:0] gx_d, gx_q, gy_d, gy_q;

    logic [AW-1:0]    gx_abs, gy_abs;
    logic [AW:0]      sel;
    logic [PIX_W-1:0] pix3_d;

    logic             out_valid_q, out_sof_q, out_eof_q;
    logic [PIX_W-1:0] out_pixel_q;

    // Frame sequencing: raster counters, mode latch and coordinates of the pixel being accepted.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        col_d   = col_q;
        row_d   = row_q;
        start   = in_valid_i & sof_i;
        accept  = 1'b0;
        pix_col = col_q;
        pix_row = row_q;
        if (start) begin
            // A start of frame in any state restarts at (0,0).
            accept  = 1'b1;
            pix_col = '0;
            pix_row = '0;
            mode_d  = mode_e'(mode_i);
            col_d   = CW'(1);
            row_d   = '0;
            state_d = StRun;
        end else begin
            case (state_q)
                StRun: begin
                    if (in_valid_i) begin
                        accept = 1'b1;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (row_q == ROW_LAST) begin
                                state_d = StDrain;
                            end else begin
                                row_d = row_q + 1'b1;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    // Leave once the end-of-frame result is on the outputs.
                    if (out_eof_q) begin
                        state_d = StIdle;
                    end
                end
                default: ;
            endcase
        end
        v1_d   = accept && (pix_row >= ROW_TWO) && (pix_col >= COL_TWO);
        sof1_d = (pix_row == ROW_TWO) && (pix_col == COL_TWO);
        eof1_d = (pix_row == ROW_LAST) && (pix_col == COL_LAST);
    end

    line_buffer #(
        .DEPTH (IMAGE_WIDTH),
        .WIDTH (PIX_W),
        .ADDR_W(CW)
    ) u_lb_row1 (
        .clk    (clk),
        .en_i   (accept),
        .addr_i (pix_col),
        .wdata_i(in_pixel_i),
        .rdata_o(lb1_rd)
    );

    line_buffer #(
        .DEPTH (IMAGE_WIDTH),
        .WIDTH (PIX_W),
        .ADDR_W(CW)
    ) u_lb_row2 (
        .clk    (clk),
        .en_i   (accept),
        .addr_i (pix_col),
        .wdata_i(lb1_rd),
        .rdata_o(lb2_rd)
    );

    // Stage 1: shift the window left and insert the new column (rows r-2, r-1, r).
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= win_q[i][1];
                win_q[i][1] <= win_q[i][2];
            end
            win_q[0][2] <= lb2_rd;
            win_q[1][2] <= lb1_rd;
            win_q[2][2] <= in_pixel_i;
        end
    end

    // Stage 2 datapath: all three kernels are evaluated every cycle.
    always_comb begin
        gsum_d  = '0;
        gx_d    = '0;
        gy_d    = '0;
        pix_ext = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                pix_ext = AW'(win_q[i][j]);
                gsum_d  = gsum_d + AW'($unsigned(KERNEL_GAUSS[i][j])) * pix_ext;
                gx_d    = gx_d + AW'(KERNEL_SOBEL_X[i][j]) * $signed(pix_ext);
                gy_d    = gy_d + AW'(KERNEL_SOBEL_Y[i][j]) * $signed(pix_ext);
            end
        end
    end

    // Stage 2 registers.
    always_ff @(posedge clk) begin
        if (v1_q) begin
            gsum_q <= gsum_d;
            gx_q   <= gx_d;
            gy_q   <= gy_d;
        end
    end

    // Stage 3 datapath: normalise the Gaussian sum or saturate the gradient magnitude.
    always_comb begin
        gx_abs = gx_q[AW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
        gy_abs = gy_q[AW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
        sel    = '0;
        pix3_d = '0;
        case (mode_q)
            MODE_SOBEL_X:   sel = {1'b0, gx_abs};
            MODE_SOBEL_Y:   sel = {1'b0, gy_abs};
            MODE_SOBEL_MAG: sel = {1'b0, gx_abs} + {1'b0, gy_abs};
            default:        sel = '0;
        endcase
        if (mode_q == MODE_GAUSS) begin
            pix3_d = gsum_q[GAUSS_SHIFT +: PIX_W];
        end else begin
            pix3_d = (|sel[AW:PIX_W]) ? '1 : sel[PIX_W-1:0];
        end
    end

    // Control state and pipeline valid/marker bits; a start of frame flushes results in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            mode_q      <= MODE_GAUSS;
            col_q       <= '0;
            row_q       <= '0;
            v1_q        <= 1'b0;
            sof1_q      <= 1'b0;
            eof1_q      <= 1'b0;
            v2_q        <= 1'b0;
            sof2_q      <= 1'b0;
            eof2_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_pixel_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            col_q       <= col_d;
            row_q       <= row_d;
            v1_q        <= v1_d;
            sof1_q      <= sof1_d;
            eof1_q      <= eof1_d;
            v2_q        <= v1_q & ~start;
            sof2_q      <= sof1_q;
            eof2_q      <= eof1_q;
            out_valid_q <= v2_q & ~start;
            out_sof_q   <= v2_q & sof2_q & ~start;
            out_eof_q   <= v2_q & eof2_q & ~start;
            if (v2_q) begin
                out_pixel_q <= pix3_d;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_pixel_o = out_pixel_q;
    assign out_sof_o   = out_sof_q;
    assign out_eof_o   = out_eof_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream on an 8x6 image with 8-bit pixels.
module tb_conv3x3_stream;

    localparam int W = 8;
    localparam int H = 6;

    logic       clk;
    logic       rst;
    logic [1:0] mode_i;
    logic       sof_i;
    logic       in_valid_i;
    logic [7:0] in_pixel_i;
    logic       out_valid_o;
    logic [7:0] out_pixel_o;
    logic       out_sof_o;
    logic       out_eof_o;
    logic       busy_o;

    typedef struct {
        logic [7:0] pix;
        logic       sof;
        logic       eof;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_out = 0;
    int n_sof = 0;
    int n_eof = 0;
    int accept_cyc = 0;
    int first_out_cyc = 0;

    int img [H][W];
    int kg [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
    int kx [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    int ky [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

    conv3x3_stream #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .PIX_W       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_i     (mode_i),
        .sof_i      (sof_i),
        .in_valid_i (in_valid_i),
        .in_pixel_i (in_pixel_i),
        .out_valid_o(out_valid_o),
        .out_pixel_o(out_pixel_o),
        .out_sof_o  (out_sof_o),
        .out_eof_o  (out_eof_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every output is popped against the expectation queued at acceptance.
    always @(negedge clk) begin
        if (out_valid_o) begin
            n_out++;
            if (out_sof_o) begin
                n_sof++;
                first_out_cyc = cyc;
            end
            if (out_eof_o) n_eof++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got pix=%0d sof=%0b eof=%0b, expected no output",
                         out_pixel_o, out_sof_o, out_eof_o);
            end else begin
                e = sb.pop_front();
                if ({out_pixel_o, out_sof_o, out_eof_o} !== {e.pix, e.sof, e.eof}) begin
                    errors++;
                    $display("FAIL scoreboard: got pix=%0d sof=%0b eof=%0b, expected pix=%0d sof=%0b eof=%0b",
                             out_pixel_o, out_sof_o, out_eof_o, e.pix, e.sof, e.eof);
                end
            end
        end
    end

    function automatic logic [7:0] model(input logic [1:0] m, input int r, input int c);
        int gs, gx, gy, p, v;
        gs = 0;
        gx = 0;
        gy = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                p  = img[r - 2 + i][c - 2 + j];
                gs += kg[i][j] * p;
                gx += kx[i][j] * p;
                gy += ky[i][j] * p;
            end
        end
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        case (m)
            2'd0:    v = gs / 16;
            2'd1:    v = gx;
            2'd2:    v = gy;
            default: v = gx + gy;
        endcase
        if (v > 255) v = 255;
        return 8'(v);
    endfunction

    task automatic fill_image(input int pat);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (pat)
                    0:       img[r][c] = 100;
                    1:       img[r][c] = (c < 4) ? 0 : 255;
                    2:       img[r][c] = (r < 3) ? 0 : 200;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
            end
        end
    endtask

    // One clock of input; returns 1 time unit after the sampling edge.
    task automatic drive(input logic v, input logic s, input logic [7:0] p);
        in_valid_i = v;
        sof_i      = s;
        in_pixel_i = p;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        sof_i      = 1'b0;
    endtask

    // Streams one frame (stopping before pixel index stop_idx when >= 0) and queues expectations.
    task automatic run_frame(input int pat, input logic [1:0] m_sof, input logic [1:0] m_after,
                             input bit gaps, input int stop_idx);
        int r, c, n;
        fill_image(pat);
        for (int idx = 0; idx < W * H; idx++) begin
            if (stop_idx >= 0 && idx == stop_idx) break;
            r = idx / W;
            c = idx % W;
            if (gaps && idx > 0) begin
                n = int'($urandom_range(0, 2));
                repeat (n) drive(1'b0, 1'b0, 8'($urandom));
            end
            mode_i = (idx == 0) ? m_sof : m_after;
            drive(1'b1, idx == 0, 8'(img[r][c]));
            if (idx == 0) begin
                sb.delete();
                n_out = 0;
                n_sof = 0;
                n_eof = 0;
            end
            if (r == 2 && c == 2) accept_cyc = cyc;
            if (r >= 2 && c >= 2) begin
                sb.push_back('{pix: model(m_sof, r, c), sof: (r == 2 && c == 2),
                               eof: (r == H - 1 && c == W - 1)});
            end
        end
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while ((busy_o || sb.size() != 0) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (k >= 200) begin
            errors++;
            $display("FAIL %s_done: busy_o=%0b pending=%0d, expected idle with 0 pending",
                     name, busy_o, sb.size());
        end
        repeat (5) drive(1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid_o, out_sof_o, out_eof_o, busy_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got valid/sof/eof/busy=%b, expected 0000",
                     {out_valid_o, out_sof_o, out_eof_o, busy_o});
        end
        checks++;
        if (out_pixel_o !== 8'd0) begin
            errors++;
            $display("FAIL reset_pixel: got %0d, expected 0", out_pixel_o);
        end
        rst = 1'b0;
        n_out = 0;
        repeat (6) drive(1'b1, 1'b0, 8'd77);
        checks++;
        if (busy_o !== 1'b0 || n_out !== 0) begin
            errors++;
            $display("FAIL idle_ignores_valid: got busy=%0b outputs=%0d, expected busy=0 outputs=0",
                     busy_o, n_out);
        end
    endtask

    task automatic test_gauss_const();
        int lat;
        run_frame(0, 2'd0, 2'd0, 1'b0, -1);
        wait_done("gauss");
        checks++;
        if (n_out !== 24) begin
            errors++;
            $display("FAIL gauss_count: got %0d outputs, expected 24", n_out);
        end
        checks++;
        if (n_sof !== 1 || n_eof !== 1) begin
            errors++;
            $display("FAIL gauss_markers: got sof=%0d eof=%0d, expected 1 and 1", n_sof, n_eof);
        end
        lat = first_out_cyc - accept_cyc + 1;
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL gauss_latency: got %0d cycles, expected 3", lat);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL gauss_busy_after: got %0b, expected 0", busy_o);
        end
    endtask

    task automatic test_sobel_vstep();
        for (int m = 1; m <= 3; m++) begin
            run_frame(1, 2'(m), 2'(m), 1'b0, -1);
            wait_done("vstep");
            checks++;
            if (n_out !== 24 || n_eof !== 1) begin
                errors++;
                $display("FAIL vstep_mode%0d_count: got outputs=%0d eof=%0d, expected 24 and 1",
                         m, n_out, n_eof);
            end
        end
    endtask

    task automatic test_sobel_hstep();
        run_frame(2, 2'd2, 2'd2, 1'b0, -1);
        wait_done("hstep");
        checks++;
        if (n_out !== 24) begin
            errors++;
            $display("FAIL hstep_count: got %0d outputs, expected 24", n_out);
        end
    endtask

    task automatic test_gaps();
        run_frame(0, 2'd0, 2'd0, 1'b1, -1);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL gaps_busy_drain: got %0b, expected 1", busy_o);
        end
        wait_done("gaps");
        checks++;
        if (n_out !== 24 || n_eof !== 1) begin
            errors++;
            $display("FAIL gaps_count: got outputs=%0d eof=%0d, expected 24 and 1", n_out, n_eof);
        end
    endtask

    task automatic test_mode_toggle();
        run_frame(3, 2'd0, 2'd1, 1'b0, -1);
        wait_done("toggle_gauss");
        checks++;
        if (n_out !== 24) begin
            errors++;
            $display("FAIL toggle_gauss_count: got %0d outputs, expected 24", n_out);
        end
        run_frame(3, 2'd1, 2'd1, 1'b0, -1);
        wait_done("toggle_sobel");
        checks++;
        if (n_out !== 24) begin
            errors++;
            $display("FAIL toggle_sobel_count: got %0d outputs, expected 24", n_out);
        end
    endtask

    task automatic test_abort();
        run_frame(1, 2'd1, 2'd1, 1'b0, 3 * W + 2);
        run_frame(0, 2'd0, 2'd0, 1'b0, -1);
        wait_done("abort");
        checks++;
        if (n_out !== 24) begin
            errors++;
            $display("FAIL abort_new_count: got %0d outputs, expected 24", n_out);
        end
        checks++;
        if (n_eof !== 1) begin
            errors++;
            $display("FAIL abort_eof: got %0d eof markers, expected 1", n_eof);
        end
    endtask

    task automatic test_reset_mid();
        run_frame(0, 2'd0, 2'd0, 1'b0, 20);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid_o, out_sof_o, out_eof_o, busy_o} !== 4'b0000 || out_pixel_o !== 8'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got valid/sof/eof/busy=%b pix=%0d, expected 0000 pix=0",
                     {out_valid_o, out_sof_o, out_eof_o, busy_o}, out_pixel_o);
        end
        sb.delete();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        n_out = 0;
        repeat (10) drive(1'b1, 1'b0, 8'd50);
        checks++;
        if (busy_o !== 1'b0 || n_out !== 0) begin
            errors++;
            $display("FAIL midreset_needs_sof: got busy=%0b outputs=%0d, expected 0 and 0",
                     busy_o, n_out);
        end
        run_frame(0, 2'd0, 2'd0, 1'b0, -1);
        wait_done("recover");
        checks++;
        if (n_out !== 24) begin
            errors++;
            $display("FAIL midreset_recover_count: got %0d outputs, expected 24", n_out);
        end
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        mode_i     = 2'd0;
        sof_i      = 1'b0;
        in_valid_i = 1'b0;
        in_pixel_i = 8'd0;
        test_reset();
        test_gauss_const();
        test_sobel_vstep();
        test_sobel_hstep();
        test_gaps();
        test_mode_toggle();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
